// File: rtl/t06_frame_diff_scanner_if.sv
// ---------------------------------------------------------------------------
// t06_frame_diff_scanner_if
// Purpose : bundles the two handshakes of the frame diff scanner: the cell
//           query towards the upstream game logic and the update record
//           stream towards the display driver.
// Signals : query_valid/req_x/req_y  - scanner asks for one cell's flags
//           obj_valid + border/head/body/apple - upstream answer
//           out_valid/out_ready       - record handshake
//           out_x/out_y/out_code/out_diff - record payload
// Modports: master = scanner side, slave = environment side.
// ---------------------------------------------------------------------------
interface t06_frame_diff_scanner_if #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3
);
  localparam int XW = ($clog2(GRID_W) > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = ($clog2(GRID_H) > 1) ? $clog2(GRID_H) : 1;

  logic              query_valid;
  logic [XW-1:0]     req_x;
  logic [YW-1:0]     req_y;
  logic              obj_valid;
  logic              border;
  logic              head;
  logic              body;
  logic              apple;
  logic              out_valid;
  logic              out_ready;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic [CODE_W-1:0] out_code;
  logic              out_diff;

  modport master (
    output query_valid, req_x, req_y,
    input  obj_valid, border, head, body, apple,
    output out_valid, out_x, out_y, out_code, out_diff,
    input  out_ready
  );

  modport slave (
    input  query_valid, req_x, req_y,
    output obj_valid, border, head, body, apple,
    input  out_valid, out_x, out_y, out_code, out_diff,
    output out_ready
  );
endinterface

// File: rtl/t06_frame_diff_scanner.sv
// ---------------------------------------------------------------------------
// t06_frame_diff_scanner
// Purpose : scans a GRID_W x GRID_H grid in raster order once per frame,
//           encodes each cell's object flags to a priority code, compares it
//           with the stored previous frame and emits update records (changed
//           cells only, or every cell). Supports a sticky forced full redraw
//           and counts differing cells per frame.
// Ports   : clk, rst (sync, active high)
//           start      - begin a scan (ignored while busy)
//           mode_all   - sampled at start: 1 emit all cells, 0 changed only
//           clear_req  - force a full redraw on the next frame
//           busy       - scan in progress
//           frame_done - one-cycle pulse at end of scan
//           diff_count - differing cells in the last/current frame
//           bus        - query + record handshakes (master modport)
// ---------------------------------------------------------------------------
module t06_frame_diff_scanner #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  mode_all,
  input  logic                                  clear_req,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0]    diff_count,
  t06_frame_diff_scanner_if.master              bus
);
  localparam int NCELL = GRID_W * GRID_H;
  localparam int XW    = ($clog2(GRID_W) > 1) ? $clog2(GRID_W) : 1;
  localparam int YW    = ($clog2(GRID_H) > 1) ? $clog2(GRID_H) : 1;
  localparam int AW    = ($clog2(NCELL) > 1) ? $clog2(NCELL) : 1;
  localparam int DW    = $clog2(NCELL + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Priority encoder: border beats head beats body beats apple.
  function automatic logic [CODE_W-1:0] enc_code(input logic b, input logic h,
                                                 input logic bo, input logic a);
    logic [2:0] c;
    if (b) begin
      c = 3'd4;
    end else if (h) begin
      c = 3'd1;
    end else if (bo) begin
      c = 3'd2;
    end else if (a) begin
      c = 3'd3;
    end else begin
      c = 3'd0;
    end
    return CODE_W'(c);
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic              mode_all_r;
  logic              force_all_r;
  logic              force_pending_r;
  logic [DW-1:0]     diff_count_r;
  logic [XW-1:0]     out_x_r;
  logic [YW-1:0]     out_y_r;
  logic [CODE_W-1:0] out_code_r;
  logic              out_diff_r;
  logic [CODE_W-1:0] frame_mem_r [NCELL];

  logic              start_ok_s;
  logic              accept_s;
  logic [AW-1:0]     cell_idx_s;
  logic [CODE_W-1:0] code_s;
  logic              diff_s;
  logic              emit_s;
  logic              last_x_s;
  logic              last_cell_s;
  logic              advance_s;
  logic              query_valid_s;
  logic              out_valid_s;
  logic              busy_s;
  logic              frame_done_s;

  assign start_ok_s  = (state_r == ST_IDLE) && start;
  assign accept_s    = (state_r == ST_QUERY) && bus.obj_valid;
  assign cell_idx_s  = AW'(y_r) * AW'(GRID_W) + AW'(x_r);
  assign code_s      = enc_code(bus.border, bus.head, bus.body, bus.apple);
  assign diff_s      = force_all_r || (code_s != frame_mem_r[cell_idx_s]);
  assign emit_s      = mode_all_r || diff_s;
  assign last_x_s    = (x_r == XW'(GRID_W - 1));
  assign last_cell_s = last_x_s && (y_r == YW'(GRID_H - 1));
  // A cell is finished either when it is silently accepted or its record is taken.
  assign advance_s   = (accept_s && !emit_s) ||
                       ((state_r == ST_EMIT) && bus.out_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_QUERY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_QUERY: begin
        if (accept_s && emit_s) begin
          state_nxt_s = ST_EMIT;
        end else if (accept_s && last_cell_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_QUERY;
        end
      end
      ST_EMIT: begin
        if (bus.out_ready && last_cell_s) begin
          state_nxt_s = ST_DONE;
        end else if (bus.out_ready) begin
          state_nxt_s = ST_QUERY;
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    query_valid_s = 1'b0;
    out_valid_s   = 1'b0;
    busy_s        = 1'b0;
    frame_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_QUERY: begin
        query_valid_s = 1'b1;
        busy_s        = 1'b1;
      end
      ST_EMIT: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      ST_DONE: begin
        busy_s       = 1'b1;
        frame_done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Scan position, frame control flags, diff counter and record latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r             <= {XW{1'b0}};
      y_r             <= {YW{1'b0}};
      mode_all_r      <= 1'b0;
      force_all_r     <= 1'b0;
      force_pending_r <= 1'b1;
      diff_count_r    <= {DW{1'b0}};
      out_x_r         <= {XW{1'b0}};
      out_y_r         <= {YW{1'b0}};
      out_code_r      <= {CODE_W{1'b0}};
      out_diff_r      <= 1'b0;
    end else begin
      // A clear_req arriving with start is folded into the frame being started.
      if (start_ok_s) begin
        force_all_r     <= force_pending_r || clear_req;
        force_pending_r <= 1'b0;
        mode_all_r      <= mode_all;
        diff_count_r    <= {DW{1'b0}};
      end else begin
        if (clear_req) begin
          force_pending_r <= 1'b1;
        end
        if (accept_s) begin
          diff_count_r <= diff_count_r + DW'(diff_s);
        end
      end

      if (start_ok_s) begin
        x_r <= {XW{1'b0}};
        y_r <= {YW{1'b0}};
      end else if (advance_s) begin
        if (last_cell_s) begin
          x_r <= {XW{1'b0}};
          y_r <= {YW{1'b0}};
        end else if (last_x_s) begin
          x_r <= {XW{1'b0}};
          y_r <= y_r + YW'(1);
        end else begin
          x_r <= x_r + XW'(1);
        end
      end

      if (accept_s && emit_s) begin
        out_x_r    <= x_r;
        out_y_r    <= y_r;
        out_code_r <= code_s;
        out_diff_r <= diff_s;
      end
    end
  end

  // Stored previous frame; written with each accepted cell's code.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCELL; i++) begin
        frame_mem_r[i] <= {CODE_W{1'b0}};
      end
    end else if (accept_s) begin
      frame_mem_r[cell_idx_s] <= code_s;
    end
  end

  assign bus.query_valid = query_valid_s;
  assign bus.req_x       = x_r;
  assign bus.req_y       = y_r;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_x       = out_x_r;
  assign bus.out_y       = out_y_r;
  assign bus.out_code    = out_code_r;
  assign bus.out_diff    = out_diff_r;
  assign busy            = busy_s;
  assign frame_done      = frame_done_s;
  assign diff_count      = diff_count_r;
endmodule
